// File: rtl/m_pte_port_if.sv
`default_nettype none
// ============================================================================
// Module      : m_pte_port_if
// Description : Walker-side PTE request pins and DRAM arbiter port bundle
//               for the PTE memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_pte_port_if;
  // walker side
  logic        w_pte_req;
  logic [31:0] w_pte_addr;
  logic        w_pte_we;
  logic [31:0] w_pte_wdata;
  logic        w_abort;
  logic        w_pte_busy;
  logic        w_pte_rvalid;
  logic        w_pte_err;
  logic [31:0] w_pte_rdata;
  // DRAM side
  logic        w_dram_req;
  logic        w_dram_we;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic        w_dram_ack;
  logic [31:0] w_dram_rdata;

  // Responder view
  modport slave (
    input  w_pte_req, w_pte_addr, w_pte_we, w_pte_wdata, w_abort,
    output w_pte_busy, w_pte_rvalid, w_pte_err, w_pte_rdata,
    output w_dram_req, w_dram_we, w_dram_addr, w_dram_wdata,
    input  w_dram_ack, w_dram_rdata
  );

  // Walker plus DRAM controller view
  modport master (
    output w_pte_req, w_pte_addr, w_pte_we, w_pte_wdata, w_abort,
    input  w_pte_busy, w_pte_rvalid, w_pte_err, w_pte_rdata,
    input  w_dram_req, w_dram_we, w_dram_addr, w_dram_wdata,
    output w_dram_ack, w_dram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/m_pte_port.sv
`default_nettype none
// ============================================================================
// Module      : m_pte_port
// Description : PTE memory responder. Turns one walker PTE read/write into a
//               single-beat DRAM transaction with alignment check, abort and
//               bounded-wait timeout. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module m_pte_port #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  wire         CLK,
  input  wire         RST_X,
  m_pte_port_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          rvalid;
  logic          err;
  logic [31:0]   rdata;
  logic          dram_req;
  logic          dram_we;
  logic [31:0]   dram_addr;
  logic [31:0]   dram_wdata;

  // Request sequencer: accept in IDLE, wait for ack/abort/timeout in ACCESS,
  // report misalignment one cycle later from FAULT.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      rvalid     <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
      dram_req   <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= 32'h0;
      dram_wdata <= 32'h0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.w_pte_req) begin
            dram_addr  <= {bus.w_pte_addr[31:2], 2'b00};
            dram_we    <= bus.w_pte_we;
            dram_wdata <= bus.w_pte_wdata;
            busy       <= 1'b1;
            if (bus.w_pte_addr[1:0] != 2'b00) begin
              state <= ST_FAULT;
            end else begin
              state    <= ST_ACCESS;
              dram_req <= 1'b1;
              cnt      <= '0;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          // ack wins over abort, abort wins over timeout
          if (bus.w_dram_ack) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            dram_req <= 1'b0;
            rvalid   <= 1'b1;
            err      <= 1'b0;
            if (!dram_we) begin
              rdata <= bus.w_dram_rdata;
            end
          end else if (bus.w_abort) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            dram_req <= 1'b0;
            err      <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            dram_req <= 1'b0;
            rvalid   <= 1'b1;
            err      <= 1'b1;
            rdata    <= 32'h0;
          end
        end
        ST_FAULT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!bus.w_abort) begin
            rvalid <= 1'b1;
            err    <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          dram_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.w_pte_busy   = busy;
  assign bus.w_pte_rvalid = rvalid;
  assign bus.w_pte_err    = err;
  assign bus.w_pte_rdata  = rdata;
  assign bus.w_dram_req   = dram_req;
  assign bus.w_dram_we    = dram_we;
  assign bus.w_dram_addr  = dram_addr;
  assign bus.w_dram_wdata = dram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_m_pte_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_pte_port
// Description : Scoreboard bench for m_pte_port with a transaction-level
//               reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_pte_port;
  localparam int TO = 8;

  logic CLK;
  logic RST_X;
  m_pte_port_if bus ();

  m_pte_port #(.TIMEOUT(TO), .CW(16)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // expected completion: {err, rdata}
  logic [32:0] sb_q[$];
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected outcome.
  always @(negedge CLK) begin
    if (RST_X && bus.w_pte_rvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected none at %0t", $time);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("cpl_err", {31'h0, bus.w_pte_err}, {31'h0, e[32]});
        check("cpl_rdata", bus.w_pte_rdata, e[31:0]);
      end
    end
  end

  // Reference outcome from the transaction description alone.
  task automatic predict(input logic [31:0] addr, input logic we, input int ack_c,
                         input int abort_c, input logic [31:0] ack_data);
    bit ack_in_time;
    if (addr[1:0] != 2'b00) begin
      if (abort_c != 1) sb_q.push_back({1'b1, model_rdata});
    end else begin
      ack_in_time = (ack_c >= 1) && (ack_c <= TO) && (abort_c == 0 || abort_c >= ack_c);
      if (ack_in_time) begin
        if (!we) model_rdata = ack_data;
        sb_q.push_back({1'b0, model_rdata});
      end else if (abort_c >= 1 && abort_c <= TO) begin
        // aborted: no completion
      end else begin
        model_rdata = 32'h0;
        sb_q.push_back({1'b1, 32'h0});
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the completing edge.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int ack_c, input int abort_c, input logic [31:0] ack_data);
    int c;
    bit done;
    predict(addr, we, ack_c, abort_c, ack_data);
    bus.w_pte_req   = 1'b1;
    bus.w_pte_addr  = addr;
    bus.w_pte_we    = we;
    bus.w_pte_wdata = wdata;
    @(posedge CLK); #1;
    bus.w_pte_req   = 1'b0;
    bus.w_pte_addr  = $urandom;
    bus.w_pte_we    = $urandom_range(0, 1);
    bus.w_pte_wdata = $urandom;
    if (addr[1:0] != 2'b00) begin
      check("fault_busy", {31'h0, bus.w_pte_busy}, 32'h1);
      check("fault_no_dram_req", {31'h0, bus.w_dram_req}, 32'h0);
      bus.w_abort = (abort_c == 1);
      @(posedge CLK); #1;
      bus.w_abort = 1'b0;
      check("fault_dram_req_after", {31'h0, bus.w_dram_req}, 32'h0);
      check("fault_rvalid", {31'h0, bus.w_pte_rvalid}, (abort_c == 1) ? 32'h0 : 32'h1);
    end else begin
      c = 1;
      done = 1'b0;
      while (!done) begin
        check("acc_busy", {31'h0, bus.w_pte_busy}, 32'h1);
        check("acc_dram_req", {31'h0, bus.w_dram_req}, 32'h1);
        check("acc_dram_addr", bus.w_dram_addr, addr);
        check("acc_dram_we", {31'h0, bus.w_dram_we}, {31'h0, we});
        if (we) check("acc_dram_wdata", bus.w_dram_wdata, wdata);
        bus.w_dram_ack   = (c == ack_c);
        bus.w_abort      = (c == abort_c);
        bus.w_dram_rdata = (c == ack_c) ? ack_data : $urandom;
        @(posedge CLK); #1;
        done = (c == ack_c) || (c == abort_c) || (c == TO) || (c > TO + 2);
        bus.w_dram_ack = 1'b0;
        bus.w_abort    = 1'b0;
        c++;
      end
      check("end_busy", {31'h0, bus.w_pte_busy}, 32'h0);
      check("end_dram_req", {31'h0, bus.w_dram_req}, 32'h0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", {31'h0, bus.w_pte_busy}, 32'h0);
    check("rst_rvalid", {31'h0, bus.w_pte_rvalid}, 32'h0);
    check("rst_err", {31'h0, bus.w_pte_err}, 32'h0);
    check("rst_rdata", bus.w_pte_rdata, 32'h0);
    check("rst_dram_req", {31'h0, bus.w_dram_req}, 32'h0);
    check("rst_dram_we", {31'h0, bus.w_dram_we}, 32'h0);
    check("rst_dram_addr", bus.w_dram_addr, 32'h0);
    check("rst_dram_wdata", bus.w_dram_wdata, 32'h0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    bus.w_pte_req = 0; bus.w_pte_addr = 0; bus.w_pte_we = 0; bus.w_pte_wdata = 0;
    bus.w_abort = 0; bus.w_dram_ack = 0; bus.w_dram_rdata = 0;
    RST_X = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs();
    RST_X = 1'b1;
    @(posedge CLK); #1;

    // read, ack in 4th ACCESS cycle
    do_txn(32'h8000_1004, 1'b0, 32'h0, 4, 0, 32'h2000_0C01);
    // write with immediate ack, back-to-back
    do_txn(32'h8000_2008, 1'b1, 32'h0000_00C7, 1, 0, 32'hDEAD_BEEF);
    // misaligned
    do_txn(32'h8000_1002, 1'b0, 32'h0, 1, 0, 32'h1111_1111);
    // timeout, then ack exactly on the last cycle
    do_txn(32'h8000_3000, 1'b0, 32'h0, 0, 0, 32'h0);
    do_txn(32'h8000_3004, 1'b0, 32'h0, TO, 0, 32'h1234_5678);
    // abort in 2nd cycle, stray ack in IDLE, then a normal request
    do_txn(32'h8000_4000, 1'b0, 32'h0, 0, 2, 32'h0);
    held = bus.w_pte_rdata;
    bus.w_dram_ack = 1'b1; bus.w_dram_rdata = 32'hBAD0_BAD0;
    @(posedge CLK); #1;
    bus.w_dram_ack = 1'b0;
    check("stray_rdata", bus.w_pte_rdata, held);
    check("stray_busy", {31'h0, bus.w_pte_busy}, 32'h0);
    check("stray_rvalid", {31'h0, bus.w_pte_rvalid}, 32'h0);
    do_txn(32'h8000_4004, 1'b0, 32'h0, 2, 0, 32'hCAFE_0001);

    // reset mid-ACCESS
    bus.w_pte_req = 1'b1; bus.w_pte_addr = 32'h8000_5000; bus.w_pte_we = 1'b1;
    bus.w_pte_wdata = 32'h5555_AAAA;
    @(posedge CLK); #1;
    bus.w_pte_req = 1'b0;
    @(posedge CLK); #1;
    RST_X = 1'b0;
    @(posedge CLK); #1;
    RST_X = 1'b1;
    model_rdata = 32'h0;
    check_reset_outputs();
    @(posedge CLK); #1;
    check_reset_outputs();
    do_txn(32'h8000_6000, 1'b0, 32'h0, 3, 0, 32'h0BAD_F00D);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int ack_c, abort_c;
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      ack_c   = $urandom_range(0, TO + 1);
      abort_c = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TO) : 0;
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, ack_c, abort_c, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.w_dram_ack = 1'($urandom_range(0, 1)); bus.w_dram_rdata = $urandom;
        @(posedge CLK); #1;
        bus.w_dram_ack = 1'b0;
      end
    end

    repeat (3) @(posedge CLK);
    #1;
    check("sb_empty", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
